// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial add/subtract sequencer.
// Latches two WIDTH-bit operands on start and feeds one 1-bit full adder
// LSB-first, one bit per clock. The carry is held in a flop between bits.
// When all bits are done, the result and flags are registered, and done
// pulses for one cycle.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           begin an operation (sampled in IDLE or DONE only)
//   sub             0: inA+inB+cin, 1: inA-inB (cin ignored)
//   inA, inB, cin   operands, sampled with start
//   busy            high while bits are being processed
//   done            one-cycle completion pulse
//   sum             result, held until the next completion
//   cout            carry out of the MSB (sub: 1 = no borrow)
//   overflow        signed overflow
//   zero            sum == 0
//   prop_all        AND of per-bit propagate over all bits

// full_adder: 1-bit full adder cell with propagate/generate outputs.
module full_adder (
  input  logic inA,
  input  logic inB,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic p,
  output logic g
);
  assign p    = inA ^ inB;
  assign g    = inA & inB;
  assign sum  = p ^ cin;
  assign cout = g | (p & cin);
endmodule

module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             prop_all
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRELAST = CW'(WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_prop_acc;
  logic             r_carry_in_msb;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_prop_all;

  logic             w_sum_bit;
  logic             w_cout_bit;
  logic             w_p_bit;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  full_adder u_fa (
    .inA  (r_a_sh[0]),
    .inB  (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_sum_bit),
    .cout (w_cout_bit),
    .p    (w_p_bit),
    .g    ()
  );

  // start is honoured only outside RUN; a start during RUN is dropped.
  assign w_load   = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);
  // Final bit lands in the MSB while the earlier bits shift down into place.
  assign w_result = {w_sum_bit, r_res_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh         <= '0;
      r_b_sh         <= '0;
      r_res_sh       <= '0;
      r_cnt          <= '0;
      r_carry        <= 1'b0;
      r_prop_acc     <= 1'b0;
      r_carry_in_msb <= 1'b0;
      r_sum          <= '0;
      r_cout         <= 1'b0;
      r_overflow     <= 1'b0;
      r_zero         <= 1'b0;
      r_prop_all     <= 1'b0;
    end else if (w_load) begin
      r_a_sh     <= inA;
      r_b_sh     <= sub ? ~inB : inB;
      r_carry    <= sub ? 1'b1 : cin;
      r_cnt      <= '0;
      r_prop_acc <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_carry    <= w_cout_bit;
      r_res_sh   <= w_result;
      r_a_sh     <= r_a_sh >> 1;
      r_b_sh     <= r_b_sh >> 1;
      r_prop_acc <= r_prop_acc & w_p_bit;
      r_cnt      <= r_cnt + CW'(1);
      if (r_cnt == PRELAST) begin
        r_carry_in_msb <= w_cout_bit;
      end
      if (w_last) begin
        r_sum      <= w_result;
        r_cout     <= w_cout_bit;
        r_overflow <= r_carry_in_msb ^ w_cout_bit;
        r_prop_all <= r_prop_acc & w_p_bit;
        r_zero     <= (w_result == '0);
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign prop_all = r_prop_all;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Testbench for serial_alu_seq: directed scenarios at WIDTH=8, then random
// back-to-back regression at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ov8, z8, p8;
  logic [7:0]  sum8;

  logic        st16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ov16, z16, p16;
  logic [15:0] sum16;

  serial_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8), .inA(a8), .inB(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .overflow(ov8), .zero(z8), .prop_all(p8)
  );

  serial_alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sub16), .inA(a16), .inB(b16),
    .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
    .overflow(ov16), .zero(z16), .prop_all(p16)
  );

  int nchk  = 0;
  int nfail = 0;

  logic [31:0] r_sum;
  logic        r_cout, r_ov, r_zero, r_prop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, input logic go);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = s; cin8 = c; st8 = go;
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; sub16 = s; cin16 = c; st16 = go;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn);
    if (w == 8) begin
      bz = busy8; dn = done8;
      r_sum = {24'd0, sum8}; r_cout = cout8; r_ov = ov8; r_zero = z8; r_prop = p8;
    end else begin
      bz = busy16; dn = done16;
      r_sum = {16'd0, sum16}; r_cout = cout16; r_ov = ov16; r_zero = z16; r_prop = p16;
    end
  endtask

  // Waits for done, counting edges and busy cycles; called #1 after edge E0.
  task automatic wait_done(input int w, output int lat, output int nb);
    logic bz, dn;
    lat = 0;
    nb  = 0;
    sample(w, bz, dn);
    while (!dn && lat < 4 * w) begin
      if (bz) nb++;
      @(posedge clk); #1;
      lat++;
      sample(w, bz, dn);
      chk("busy_done_excl", {31'd0, bz & dn}, 32'd0);
    end
  endtask

  task automatic check_model(input int w, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic c, input string tag);
    logic [31:0] mask, bb, esum;
    logic [63:0] full;
    logic        eov;
    mask = (w == 8) ? 32'hFF : 32'hFFFF;
    bb   = s ? (~b & mask) : (b & mask);
    full = 64'(a & mask) + 64'(bb) + 64'(s ? 1'b1 : c);
    esum = full[31:0] & mask;
    eov  = (a[w-1] == bb[w-1]) && (esum[w-1] != a[w-1]);
    chk({tag, "_sum"},  r_sum, esum);
    chk({tag, "_cout"}, {31'd0, r_cout}, {31'd0, full[w]});
    chk({tag, "_ovf"},  {31'd0, r_ov}, {31'd0, eov});
    chk({tag, "_zero"}, {31'd0, r_zero}, {31'd0, esum == 32'd0});
    chk({tag, "_prop"}, {31'd0, r_prop}, {31'd0, ((a ^ bb) & mask) == mask});
  endtask

  // Full operation: start on the next edge, scramble inputs afterwards,
  // then check handshake timing and the result against the model.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, input string tag);
    int lat, nb;
    logic bz, dn;
    drive(w, a, b, s, c, 1'b1);
    @(posedge clk); #1;
    drive(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    sample(w, bz, dn);
    chk({tag, "_busy0"}, {31'd0, bz}, 32'd1);
    wait_done(w, lat, nb);
    chk({tag, "_lat"}, lat, w);
    chk({tag, "_nbusy"}, nb, w);
    check_model(w, a, b, s, c, tag);
  endtask

  initial begin
    logic bz, dn;
    int   lat, nb;

    // Reset values
    #1;
    sample(8, bz, dn);
    chk("rst_busy", {31'd0, bz}, 32'd0);
    chk("rst_done", {31'd0, dn}, 32'd0);
    chk("rst_sum", r_sum, 32'd0);
    chk("rst_flags", {28'd0, r_cout, r_ov, r_zero, r_prop}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic add with overflow
    do_op(8, 32'h5A, 32'h3C, 1'b0, 1'b0, "add5A3C");
    chk("add5A3C_const", {r_sum[7:0], r_cout, r_ov, r_zero, r_prop}, {8'h96, 4'b0100});

    // Subtract; cin must be ignored
    do_op(8, 32'h10, 32'h20, 1'b1, 1'b0, "sub_c0");
    chk("sub_c0_const", r_sum, 32'hF0);
    do_op(8, 32'h10, 32'h20, 1'b1, 1'b1, "sub_c1");
    chk("sub_c1_const", {r_sum[7:0], r_cout, r_ov, r_zero}, {8'hF0, 3'b000});

    // Zero results, with and without full propagate
    do_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, "zeroA");
    chk("zeroA_const", {r_sum[7:0], r_cout, r_ov, r_zero, r_prop}, {8'h00, 4'b1010});
    do_op(8, 32'hF0, 32'h0F, 1'b0, 1'b1, "zeroB");
    chk("zeroB_const", {r_sum[7:0], r_cout, r_zero, r_prop}, {8'h00, 3'b111});

    // start during RUN is ignored
    drive(8, 32'h01, 32'h01, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    drive(8, 32'h7F, 32'h7F, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0);
    wait_done(8, lat, nb);
    chk("ignore_lat", lat, 5);
    chk("ignore_sum", r_sum, 32'h02);
    // Back-to-back from the DONE cycle
    do_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, "b2b");
    chk("b2b_const", {r_sum[7:0], r_ov}, {8'h80, 1'b1});

    // Reset mid-RUN aborts with no done pulse
    drive(8, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 32'h00, 32'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    sample(8, bz, dn);
    chk("abort_busy", {31'd0, bz}, 32'd0);
    chk("abort_outs", {r_sum[7:0], dn, r_cout, r_ov, r_zero, r_prop}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      sample(8, bz, dn);
      chk("abort_nodone", {30'd0, bz, dn}, 32'd0);
    end
    do_op(8, 32'h01, 32'h02, 1'b0, 1'b0, "post_rst");
    chk("post_rst_const", r_sum, 32'h03);

    // Random back-to-back regression at both widths
    for (int i = 0; i < 1000; i++)
      do_op(8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd8");
    for (int i = 0; i < 1000; i++)
      do_op(16, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd16");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
